multicycle_control_unit: RTL and testbench

Moore-style FSM control unit for the multi-cycle MIPS datapath, the successor to the single-cycle combinational decoder. It decodes Opcode/funct from the latched instruction register and sequences one instruction over 3–5+ cycles. It drives the PC, IR, memory, register-file and ALU controls. It adds a memory-ready handshake and parametrised handling of illegal instructions.

---
 rtl/mcu_pkg.sv | 58 +++++
 rtl/multicycle_control_unit_alu_decoder.sv | 34 +++
 rtl/multicycle_control_unit.sv | 171 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared constants for the multi-cycle MIPS control unit:
// state codes, opcode/funct values and datapath select encodings.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;

  localparam logic [1:0] INSEL_B    = 2'b00;
  localparam logic [1:0] INSEL_FOUR = 2'b01;
  localparam logic [1:0] INSEL_IMM  = 2'b10;
  localparam logic [1:0] INSEL_IMM2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_legal_funct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU operation decoder: ALUOp plus funct to ALUsel.
// Unknown R-type funct values fall back to ADD.
import mcu_pkg::*;

module alu_decoder #(
  parameter int ALUSEL_W = 4
) (
  input  logic [5:0]          i_funct,
  input  logic [1:0]          i_aluop,
  output logic [ALUSEL_W-1:0] o_alusel
);

  logic [3:0] w_sel;

  // Select the ALU operation from ALUOp, consulting funct for R-type
  always_comb begin
    w_sel = ALU_ADD;
    if (i_aluop == AOP_SUB) begin
      w_sel = ALU_SUB;
    end else if (i_aluop == AOP_FUNCT) begin
      case (i_funct)
        FN_ADD:  w_sel = ALU_ADD;
        FN_SUB:  w_sel = ALU_SUB;
        FN_AND:  w_sel = ALU_AND;
        FN_OR:   w_sel = ALU_OR;
        FN_SLT:  w_sel = ALU_SLT;
        default: w_sel = ALU_ADD;
      endcase
    end
  end

  assign o_alusel = ALUSEL_W'(w_sel);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute with a memory-ready handshake.
import mcu_pkg::*;

module multicycle_control_unit #(
  parameter int ALUSEL_W        = 4,
  parameter bit HAS_MEM_RDY     = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          Opcode,
  input  logic [5:0]          funct,
  input  logic                MemRdy,
  output logic                MemReq,
  output logic                IorD,
  output logic                IRWE,
  output logic                PCWE,
  output logic                Branch,
  output logic                DMWE,
  output logic                MtoRFSel,
  output logic                RFDSel,
  output logic                RFWE,
  output logic                ALUSrcA,
  output logic [1:0]          ALUInSel,
  output logic [1:0]          PCSrc,
  output logic [ALUSEL_W-1:0] ALUsel,
  output logic                Illegal,
  output logic [3:0]          State
);

  state_t     r_state;
  state_t     w_next;
  logic       w_rdy;
  logic [1:0] w_aluop;

  assign w_rdy = HAS_MEM_RDY ? MemRdy : 1'b1;
  assign State = r_state;

  // State register; reset returns to FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore outputs, strobes gated off during reset
  always_comb begin
    w_next   = S_FETCH;
    MemReq   = 1'b0;
    IorD     = 1'b0;
    IRWE     = 1'b0;
    PCWE     = 1'b0;
    Branch   = 1'b0;
    DMWE     = 1'b0;
    MtoRFSel = 1'b0;
    RFDSel   = 1'b0;
    RFWE     = 1'b0;
    ALUSrcA  = 1'b0;
    ALUInSel = INSEL_B;
    PCSrc    = PC_ALU;
    w_aluop  = AOP_ADD;
    Illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemReq   = 1'b1;
        ALUInSel = INSEL_FOUR;
        IRWE     = w_rdy;
        PCWE     = w_rdy;
        w_next   = w_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUInSel = INSEL_IMM2;
        case (Opcode)
          OP_RTYPE: w_next = is_legal_funct(funct) ? S_EXEC : S_TRAP;
          OP_LW:    w_next = S_MEMADR;
          OP_SW:    w_next = S_MEMADR;
          OP_BEQ:   w_next = S_BRANCH;
          OP_ADDI:  w_next = S_ADDIEX;
          OP_J:     w_next = S_JUMP;
          default:  w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA  = 1'b1;
        ALUInSel = INSEL_IMM;
        w_next   = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        w_next = w_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RFWE     = 1'b1;
        MtoRFSel = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        DMWE   = w_rdy;
        w_next = w_rdy ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        w_aluop = AOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RFWE   = 1'b1;
        RFDSel = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        w_aluop = AOP_SUB;
        PCSrc   = PC_ALUOUT;
        Branch  = 1'b1;
        w_next  = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA  = 1'b1;
        ALUInSel = INSEL_IMM;
        w_next   = S_ADDIWB;
      end
      S_ADDIWB: begin
        RFWE   = 1'b1;
        w_next = S_FETCH;
      end
      S_JUMP: begin
        PCSrc  = PC_JUMP;
        PCWE   = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP: begin
        Illegal = 1'b1;
        w_next  = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    if (rst) begin
      MemReq   = 1'b0;
      IorD     = 1'b0;
      IRWE     = 1'b0;
      PCWE     = 1'b0;
      Branch   = 1'b0;
      DMWE     = 1'b0;
      MtoRFSel = 1'b0;
      RFDSel   = 1'b0;
      RFWE     = 1'b0;
      ALUSrcA  = 1'b0;
      ALUInSel = INSEL_FOUR;
      PCSrc    = PC_ALU;
      w_aluop  = AOP_ADD;
      Illegal  = 1'b0;
      w_next   = S_FETCH;
    end
  end

  alu_decoder #(
    .ALUSEL_W (ALUSEL_W)
  ) u_alu_dec (
    .i_funct  (funct),
    .i_aluop  (w_aluop),
    .o_alusel (ALUsel)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: vector table
// plus reset, trap and no-handshake sequences.
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst;
  logic [5:0] Opcode;
  logic [5:0] funct;
  logic       MemRdy;

  logic       a_mreq, a_iord, a_irwe, a_pcwe, a_br, a_dmwe;
  logic       a_mtorf, a_rfd, a_rfwe, a_srca, a_ill;
  logic [1:0] a_insel, a_pcsrc;
  logic [3:0] a_alu, a_st;

  logic       b_mreq, b_iord, b_irwe, b_pcwe, b_br, b_dmwe;
  logic       b_mtorf, b_rfd, b_rfwe, b_srca, b_ill;
  logic [1:0] b_insel, b_pcsrc;
  logic [3:0] b_alu, b_st;

  int errors = 0;
  int checks = 0;

  multicycle_control_unit #(
    .ALUSEL_W(4), .HAS_MEM_RDY(1'b1), .TRAP_ON_ILLEGAL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .funct(funct),
    .MemRdy(MemRdy), .MemReq(a_mreq), .IorD(a_iord),
    .IRWE(a_irwe), .PCWE(a_pcwe), .Branch(a_br), .DMWE(a_dmwe),
    .MtoRFSel(a_mtorf), .RFDSel(a_rfd), .RFWE(a_rfwe),
    .ALUSrcA(a_srca), .ALUInSel(a_insel), .PCSrc(a_pcsrc),
    .ALUsel(a_alu), .Illegal(a_ill), .State(a_st)
  );

  multicycle_control_unit #(
    .ALUSEL_W(4), .HAS_MEM_RDY(1'b0), .TRAP_ON_ILLEGAL(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .Opcode(Opcode), .funct(funct),
    .MemRdy(MemRdy), .MemReq(b_mreq), .IorD(b_iord),
    .IRWE(b_irwe), .PCWE(b_pcwe), .Branch(b_br), .DMWE(b_dmwe),
    .MtoRFSel(b_mtorf), .RFDSel(b_rfd), .RFWE(b_rfwe),
    .ALUSrcA(b_srca), .ALUInSel(b_insel), .PCSrc(b_pcsrc),
    .ALUsel(b_alu), .Illegal(b_ill), .State(b_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {MemReq IorD IRWE PCWE Branch DMWE MtoRF RFD RFWE SrcA}
  // {ALUInSel} {PCSrc} {ALUsel} {Illegal}
  localparam logic [18:0] O_RST =
    {10'b0000000000, 2'b01, 2'b00, 4'd2, 1'b0};
  localparam logic [18:0] O_FWAIT =
    {10'b1000000000, 2'b01, 2'b00, 4'd2, 1'b0};
  localparam logic [18:0] O_FRDY =
    {10'b1011000000, 2'b01, 2'b00, 4'd2, 1'b0};
  localparam logic [18:0] O_DEC =
    {10'b0000000000, 2'b11, 2'b00, 4'd2, 1'b0};
  localparam logic [18:0] O_MADR =
    {10'b0000000001, 2'b10, 2'b00, 4'd2, 1'b0};
  localparam logic [18:0] O_MRD =
    {10'b1100000000, 2'b00, 2'b00, 4'd2, 1'b0};
  localparam logic [18:0] O_MWB =
    {10'b0000001010, 2'b00, 2'b00, 4'd2, 1'b0};
  localparam logic [18:0] O_WWAIT =
    {10'b1100000000, 2'b00, 2'b00, 4'd2, 1'b0};
  localparam logic [18:0] O_WRDY =
    {10'b1100010000, 2'b00, 2'b00, 4'd2, 1'b0};
  localparam logic [18:0] O_AWB =
    {10'b0000000110, 2'b00, 2'b00, 4'd2, 1'b0};
  localparam logic [18:0] O_BR =
    {10'b0000100001, 2'b00, 2'b01, 4'd6, 1'b0};
  localparam logic [18:0] O_AIEX =
    {10'b0000000001, 2'b10, 2'b00, 4'd2, 1'b0};
  localparam logic [18:0] O_AIWB =
    {10'b0000000010, 2'b00, 2'b00, 4'd2, 1'b0};
  localparam logic [18:0] O_J =
    {10'b0001000000, 2'b00, 2'b10, 4'd2, 1'b0};
  localparam logic [18:0] O_TRAP =
    {10'b0000000000, 2'b00, 2'b00, 4'd2, 1'b1};

  function automatic logic [18:0] o_ex(input logic [3:0] a);
    return {10'b0000000001, 2'b00, 2'b00, a, 1'b0};
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] out;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input logic [3:0] st,
                     input logic [18:0] out);
    vq.push_back('{1'b0, op, fn, rdy, st, out});
  endtask

  // Drive one cycle, compare state and outputs, advance to next negedge
  task automatic step(input bit sel, input logic r,
                      input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input logic [3:0] est,
                      input logic [18:0] eout, input string nm);
    logic [18:0] got;
    logic [3:0]  gst;
    rst = r; Opcode = op; funct = fn; MemRdy = rdy;
    #1;
    if (sel) begin
      gst = b_st;
      got = {b_mreq, b_iord, b_irwe, b_pcwe, b_br, b_dmwe, b_mtorf,
             b_rfd, b_rfwe, b_srca, b_insel, b_pcsrc, b_alu, b_ill};
    end else begin
      gst = a_st;
      got = {a_mreq, a_iord, a_irwe, a_pcwe, a_br, a_dmwe, a_mtorf,
             a_rfd, a_rfwe, a_srca, a_insel, a_pcsrc, a_alu, a_ill};
    end
    checks++;
    if (gst !== est) begin
      errors++;
      $display("FAIL %s state got %0d want %0d", nm, gst, est);
    end
    checks++;
    if (got !== eout) begin
      errors++;
      $display("FAIL %s outputs got %b want %b", nm, got, eout);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; Opcode = '0; funct = '0; MemRdy = 1'b0;
    @(negedge clk);
    step(0, 1, 6'd0, 6'd0, 1, 4'd0, O_RST, "reset");

    // R-type add
    add(6'd0, 6'd32, 1, 4'd0, O_FRDY);
    add(6'd0, 6'd32, 1, 4'd1, O_DEC);
    add(6'd0, 6'd32, 1, 4'd6, o_ex(4'd2));
    add(6'd0, 6'd32, 1, 4'd7, O_AWB);
    // lw, two wait cycles in MEMRD
    add(6'd35, 6'd0, 1, 4'd0, O_FRDY);
    add(6'd35, 6'd0, 1, 4'd1, O_DEC);
    add(6'd35, 6'd0, 1, 4'd2, O_MADR);
    add(6'd35, 6'd0, 0, 4'd3, O_MRD);
    add(6'd35, 6'd0, 0, 4'd3, O_MRD);
    add(6'd35, 6'd0, 1, 4'd3, O_MRD);
    add(6'd35, 6'd0, 1, 4'd4, O_MWB);
    // sw, one wait cycle in MEMWR
    add(6'd43, 6'd0, 1, 4'd0, O_FRDY);
    add(6'd43, 6'd0, 1, 4'd1, O_DEC);
    add(6'd43, 6'd0, 1, 4'd2, O_MADR);
    add(6'd43, 6'd0, 0, 4'd5, O_WWAIT);
    add(6'd43, 6'd0, 1, 4'd5, O_WRDY);
    // beq then j
    add(6'd4, 6'd0, 1, 4'd0, O_FRDY);
    add(6'd4, 6'd0, 1, 4'd1, O_DEC);
    add(6'd4, 6'd0, 1, 4'd8, O_BR);
    add(6'd2, 6'd0, 1, 4'd0, O_FRDY);
    add(6'd2, 6'd0, 1, 4'd1, O_DEC);
    add(6'd2, 6'd0, 1, 4'd11, O_J);
    // slow fetch, R-type sub
    add(6'd0, 6'd34, 0, 4'd0, O_FWAIT);
    add(6'd0, 6'd34, 0, 4'd0, O_FWAIT);
    add(6'd0, 6'd34, 0, 4'd0, O_FWAIT);
    add(6'd0, 6'd34, 1, 4'd0, O_FRDY);
    add(6'd0, 6'd34, 1, 4'd1, O_DEC);
    add(6'd0, 6'd34, 1, 4'd6, o_ex(4'd6));
    add(6'd0, 6'd34, 1, 4'd7, O_AWB);
    // and / or / slt
    add(6'd0, 6'd36, 1, 4'd0, O_FRDY);
    add(6'd0, 6'd36, 1, 4'd1, O_DEC);
    add(6'd0, 6'd36, 1, 4'd6, o_ex(4'd0));
    add(6'd0, 6'd36, 1, 4'd7, O_AWB);
    add(6'd0, 6'd37, 1, 4'd0, O_FRDY);
    add(6'd0, 6'd37, 1, 4'd1, O_DEC);
    add(6'd0, 6'd37, 1, 4'd6, o_ex(4'd1));
    add(6'd0, 6'd37, 1, 4'd7, O_AWB);
    add(6'd0, 6'd42, 1, 4'd0, O_FRDY);
    add(6'd0, 6'd42, 1, 4'd1, O_DEC);
    add(6'd0, 6'd42, 1, 4'd6, o_ex(4'd7));
    add(6'd0, 6'd42, 1, 4'd7, O_AWB);
    // addi
    add(6'd8, 6'd0, 1, 4'd0, O_FRDY);
    add(6'd8, 6'd0, 1, 4'd1, O_DEC);
    add(6'd8, 6'd0, 1, 4'd9, O_AIEX);
    add(6'd8, 6'd0, 1, 4'd10, O_AIWB);
    // illegal opcode 63, sticky trap
    add(6'd63, 6'd0, 1, 4'd0, O_FRDY);
    add(6'd63, 6'd0, 1, 4'd1, O_DEC);
    add(6'd63, 6'd0, 1, 4'd12, O_TRAP);
    add(6'd63, 6'd0, 1, 4'd12, O_TRAP);
    add(6'd63, 6'd0, 0, 4'd12, O_TRAP);

    foreach (vq[i]) begin
      step(0, vq[i].rst, vq[i].op, vq[i].fn, vq[i].rdy,
           vq[i].st, vq[i].out, $sformatf("vec%0d", i));
    end

    // Reset out of trap, then illegal funct traps again
    step(0, 1, 6'd0, 6'd7, 1, 4'd12, O_RST, "rst_trap");
    step(0, 0, 6'd0, 6'd7, 1, 4'd0, O_FRDY, "fn7_fetch");
    step(0, 0, 6'd0, 6'd7, 1, 4'd1, O_DEC, "fn7_dec");
    step(0, 0, 6'd0, 6'd7, 1, 4'd12, O_TRAP, "fn7_trap");
    step(0, 0, 6'd0, 6'd7, 1, 4'd12, O_TRAP, "fn7_stick");

    // Reset during MEMWR with MemRdy high: no DMWE
    step(0, 1, 6'd43, 6'd0, 1, 4'd12, O_RST, "rst2");
    step(0, 0, 6'd43, 6'd0, 1, 4'd0, O_FRDY, "sw_fetch");
    step(0, 0, 6'd43, 6'd0, 1, 4'd1, O_DEC, "sw_dec");
    step(0, 0, 6'd43, 6'd0, 1, 4'd2, O_MADR, "sw_madr");
    step(0, 1, 6'd43, 6'd0, 1, 4'd5, O_RST, "rst_memwr");
    step(0, 0, 6'd43, 6'd0, 1, 4'd0, O_FRDY, "after_rst");

    // No handshake, no trap: MemRdy held low and ignored
    step(1, 1, 6'd63, 6'd0, 0, 4'd1, O_RST, "b_rst");
    step(1, 0, 6'd63, 6'd0, 0, 4'd0, O_FRDY, "b_fetch");
    step(1, 0, 6'd63, 6'd0, 0, 4'd1, O_DEC, "b_dec");
    step(1, 0, 6'd63, 6'd0, 0, 4'd12, O_TRAP, "b_trap");
    step(1, 0, 6'd0, 6'd7, 0, 4'd0, O_FRDY, "b_fetch2");
    step(1, 0, 6'd0, 6'd7, 0, 4'd1, O_DEC, "b_dec2");
    step(1, 0, 6'd0, 6'd7, 0, 4'd12, O_TRAP, "b_trap2");
    step(1, 0, 6'd35, 6'd0, 0, 4'd0, O_FRDY, "b_lw_f");
    step(1, 0, 6'd35, 6'd0, 0, 4'd1, O_DEC, "b_lw_d");
    step(1, 0, 6'd35, 6'd0, 0, 4'd2, O_MADR, "b_lw_a");
    step(1, 0, 6'd35, 6'd0, 0, 4'd3, O_MRD, "b_lw_rd");
    step(1, 0, 6'd35, 6'd0, 0, 4'd4, O_MWB, "b_lw_wb");
    step(1, 0, 6'd43, 6'd0, 0, 4'd0, O_FRDY, "b_sw_f");
    step(1, 0, 6'd43, 6'd0, 0, 4'd1, O_DEC, "b_sw_d");
    step(1, 0, 6'd43, 6'd0, 0, 4'd2, O_MADR, "b_sw_a");
    step(1, 0, 6'd43, 6'd0, 0, 4'd5, O_WRDY, "b_sw_wr");
    step(1, 0, 6'd43, 6'd0, 0, 4'd0, O_FRDY, "b_sw_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
